bundler_stream: RTL and testbench

BUNDLER_STREAM -- requirements
Module: bundler_stream

---
 rtl/bundler_stream.sv | 126 ++++++++++++
 tb/tb_bundler_stream.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bundler_stream.sv
`default_nettype none
// ============================================================================
// bundler_stream : streaming per-bit majority bundler (optional threshold mode
// via BUNDLER_STREAM_THRESHOLD_EN).  Revision 1.0
// ============================================================================
module bundler_stream #(
  parameter  int MAX_HVS  = 17,
  parameter  int PAR_BITS = 10,
  localparam int CW       = $clog2(MAX_HVS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CW-1:0]       num_hvs,
  input  logic [PAR_BITS-1:0] tie_bits,
`ifdef BUNDLER_STREAM_THRESHOLD_EN
  input  logic [CW-1:0]       threshold,
`endif
  input  logic                in_valid,
  input  logic [PAR_BITS-1:0] in_bits,
  output logic                in_ready,
  output logic                out_valid,
  output logic [PAR_BITS-1:0] out_bits,
  input  logic                out_ready,
  output logic                busy,
  output logic                err
);

  localparam logic [1:0]    S_IDLE   = 2'd0;
  localparam logic [1:0]    S_ACCUM  = 2'd1;
  localparam logic [1:0]    S_OUTPUT = 2'd2;
  localparam logic [CW-1:0] MAX_C    = CW'(MAX_HVS);

  logic [1:0]          state;
  logic [CW-1:0]       cnt [PAR_BITS];
  logic [CW-1:0]       next_cnt [PAR_BITS];
  logic [CW-1:0]       beat_cnt;
  logic [CW-1:0]       n_lat;
  logic [PAR_BITS-1:0] result;

`ifdef BUNDLER_STREAM_THRESHOLD_EN
  logic [CW-1:0]       thr_lat;
  logic                unused_tie;
  assign unused_tie = ^tie_bits;
`else
  logic [PAR_BITS-1:0] tie_lat;
`endif

  logic n_legal, start_ok, start_bad, beat, last_beat;

  assign n_legal   = (num_hvs != '0) && (num_hvs <= MAX_C);
  assign start_ok  = (state == S_IDLE) && start && n_legal;
  assign start_bad = (state == S_IDLE) && start && !n_legal;
  assign in_ready  = (state == S_ACCUM);
  assign out_valid = (state == S_OUTPUT);
  assign busy      = (state != S_IDLE);
  assign beat      = in_valid && in_ready;
  assign last_beat = beat && ((beat_cnt + CW'(1)) == n_lat);

  // Result is formed from the counts including the final beat, so it is
  // ready to register on the same edge that enters OUTPUT.
  always_comb begin
    for (int i = 0; i < PAR_BITS; i++) begin
      next_cnt[i] = cnt[i] + CW'(in_bits[i]);
`ifdef BUNDLER_STREAM_THRESHOLD_EN
      result[i] = (next_cnt[i] >= thr_lat);
`else
      if ({next_cnt[i], 1'b0} > {1'b0, n_lat})
        result[i] = 1'b1;
      else if ({next_cnt[i], 1'b0} < {1'b0, n_lat})
        result[i] = 1'b0;
      else
        result[i] = tie_lat[i];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      n_lat    <= '0;
      out_bits <= '0;
      err      <= 1'b0;
      for (int i = 0; i < PAR_BITS; i++) cnt[i] <= '0;
`ifdef BUNDLER_STREAM_THRESHOLD_EN
      thr_lat  <= '0;
`else
      tie_lat  <= '0;
`endif
    end else begin
      err <= start_bad;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            for (int i = 0; i < PAR_BITS; i++) cnt[i] <= '0;
            n_lat    <= num_hvs;
            beat_cnt <= '0;
`ifdef BUNDLER_STREAM_THRESHOLD_EN
            thr_lat  <= threshold;
`else
            tie_lat  <= tie_bits;
`endif
            state    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (beat) begin
            for (int i = 0; i < PAR_BITS; i++) cnt[i] <= next_cnt[i];
            beat_cnt <= beat_cnt + CW'(1);
            if (last_beat) begin
              out_bits <= result;
              state    <= S_OUTPUT;
            end
          end
        end
        S_OUTPUT: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bundler_stream.sv
`default_nettype none
// tb_bundler_stream : scoreboard bench for bundler_stream (majority mode, or
// threshold mode when BUNDLER_STREAM_THRESHOLD_EN is defined).
module tb_bundler_stream;
  localparam int MAX_HVS  = 17;
  localparam int PAR_BITS = 10;
  localparam int CW       = $clog2(MAX_HVS + 1);

  logic                clk = 1'b0;
  logic                rst, start, in_valid, in_ready, out_valid, out_ready, busy, err;
  logic [CW-1:0]       num_hvs;
  logic [PAR_BITS-1:0] tie_bits, in_bits, out_bits;
`ifdef BUNDLER_STREAM_THRESHOLD_EN
  logic [CW-1:0]       threshold;
`endif

  bundler_stream #(.MAX_HVS(MAX_HVS), .PAR_BITS(PAR_BITS)) dut (
    .clk(clk), .rst(rst), .start(start), .num_hvs(num_hvs), .tie_bits(tie_bits),
`ifdef BUNDLER_STREAM_THRESHOLD_EN
    .threshold(threshold),
`endif
    .in_valid(in_valid), .in_bits(in_bits), .in_ready(in_ready),
    .out_valid(out_valid), .out_bits(out_bits), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  int n_exp = 0;
  logic [PAR_BITS-1:0] exp_q [$];
  logic [PAR_BITS-1:0] beats [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PAR_BITS-1:0] model(input int n, input logic [PAR_BITS-1:0] tie,
                                                input int thr);
    logic [PAR_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < PAR_BITS; i++) begin
      int c;
      c = 0;
      for (int k = 0; k < n; k++) c += int'(beats[k][i]);
`ifdef BUNDLER_STREAM_THRESHOLD_EN
      r[i] = (c >= thr);
`else
      if (2 * c > n)      r[i] = 1'b1;
      else if (2 * c < n) r[i] = 1'b0;
      else                r[i] = tie[i];
`endif
    end
    return r;
  endfunction

  // Output side of the scoreboard
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) check("unexpected_output", 32'(out_bits), 32'hFFFF_FFFF);
      else                   check("out_bits", 32'(out_bits), 32'(exp_q.pop_front()));
    end
  end

  // Called at #1 after an edge; start is driven immediately.
  task automatic run_bundle(input int n, input logic [PAR_BITS-1:0] tie, input int thr,
                            input bit gaps, input int stall);
    logic [PAR_BITS-1:0] e;
    e = model(n, tie, thr);
    out_ready = (stall == 0);
    start     = 1'b1;
    num_hvs   = CW'(n);
    tie_bits  = tie;
`ifdef BUNDLER_STREAM_THRESHOLD_EN
    threshold = CW'(thr);
`endif
    @(posedge clk); #1;
    start = 1'b0;
    check("start_to_ready", 32'(in_ready), 32'd1);
    check("busy_accum", 32'(busy), 32'd1);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_bits  = ~beats[k];
        start    = 1'b1;
        num_hvs  = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("no_err_outside_idle", 32'(err), 32'd0);
      end
      in_valid = 1'b1;
      in_bits  = beats[k];
      if (k == n - 1) begin
        exp_q.push_back(e);
        n_exp++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("beat_to_valid", 32'(out_valid), 32'd1);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      in_bits  = PAR_BITS'($urandom);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_bits", 32'(out_bits), 32'(e));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    check("valid_before_hs", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("valid_after_hs", 32'(out_valid), 32'd0);
    check("busy_after_hs", 32'(busy), 32'd0);
    check("out_retained", 32'(out_bits), 32'(e));
    beats.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_bits = '0;
    num_hvs = '0; tie_bits = '0; out_ready = 1'b1;
`ifdef BUNDLER_STREAM_THRESHOLD_EN
    threshold = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_out_bits", 32'(out_bits), 32'd0);

    // First start on the very first edge with rst low
    rst   = 1'b0;
    beats = '{10'h3FF, 10'h000, 10'h3FF};
    run_bundle(3, 10'h000, 2, 1'b0, 0);

    // Even count tie resolved by tie_bits (back-to-back start)
    beats = '{10'h3FF, 10'h000};
    run_bundle(2, 10'h155, 1, 1'b0, 0);

    // Full-size bundle with gapped input and stalled output
    for (int k = 0; k < MAX_HVS; k++) beats.push_back(PAR_BITS'($urandom));
    run_bundle(MAX_HVS, PAR_BITS'($urandom), 9, 1'b1, 5);

    // Illegal starts
    start = 1'b1; num_hvs = '0;
    @(posedge clk); #1;
    check("err_zero", 32'(err), 32'd1);
    check("err_zero_busy", 32'(busy), 32'd0);
    num_hvs = CW'(MAX_HVS + 1);
    @(posedge clk); #1;
    start = 1'b0;
    check("err_over", 32'(err), 32'd1);
    check("err_over_busy", 32'(busy), 32'd0);
    check("err_over_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("err_one_cycle", 32'(err), 32'd0);

    // Abort a bundle with reset after 4 beats
    start = 1'b1; num_hvs = CW'(MAX_HVS); tie_bits = '0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_bits = 10'h3FF;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_out_bits", 32'(out_bits), 32'd0);
    rst   = 1'b0;
    beats = '{10'h2AA};
    run_bundle(1, 10'h000, 1, 1'b0, 0);

    // Randomised bundles
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(1, MAX_HVS));
      for (int k = 0; k < n; k++) beats.push_back(PAR_BITS'($urandom));
      run_bundle(n, PAR_BITS'($urandom), int'($urandom_range(0, n)), r[0], r % 3);
    end

`ifdef BUNDLER_STREAM_THRESHOLD_EN
    beats = '{10'h001, 10'h001, 10'h002, 10'h000};
    run_bundle(4, 10'h000, 2, 1'b0, 0);
    beats = '{10'h000, 10'h000};
    run_bundle(2, 10'h000, 0, 1'b0, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("output_count", 32'(n_out), 32'(n_exp));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
